// File: rtl/mac_vector.sv
// Three-stage signed multiply-accumulate engine producing one dot product per LEN valid terms.
// Accumulation either saturates or wraps; ovf reports any overflow seen within the finished vector.
module mac_vector #(
  parameter int WIDTH     = 14,
  parameter int ACC_WIDTH = 28,
  parameter int LEN       = 4,
  parameter int SAT       = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        valid_in,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  output logic signed [ACC_WIDTH-1:0] f,
  output logic                        valid_out,
  output logic                        ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0]     r_s1_a;
  logic signed [WIDTH-1:0]     r_s1_b;
  logic                        r_s1_v;
  logic signed [PW-1:0]        r_s2_p;
  logic                        r_s2_v;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [CW-1:0]               r_cnt;
  logic                        r_sticky;

  logic signed [PW-1:0]        w_a_ext;
  logic signed [PW-1:0]        w_b_ext;
  logic signed [PW-1:0]        w_prod;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH:0]   w_sum;
  logic                        w_ovf;
  logic signed [ACC_WIDTH-1:0] w_sum_res;
  logic                        w_last;

  // Operands are widened before multiplying so the full-precision product is kept.
  assign w_a_ext    = {{WIDTH{r_s1_a[WIDTH-1]}}, r_s1_a};
  assign w_b_ext    = {{WIDTH{r_s1_b[WIDTH-1]}}, r_s1_b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = ACC_WIDTH'(r_s2_p);
  assign w_sum      = (ACC_WIDTH+1)'(r_acc) + (ACC_WIDTH+1)'(w_prod_ext);
  assign w_ovf      = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
  assign w_last     = (r_cnt == CNT_LAST);

  always_comb begin
    w_sum_res = w_sum[ACC_WIDTH-1:0];
    if ((SAT != 0) && w_ovf) begin
      w_sum_res = w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_a <= '0;
      r_s1_b <= '0;
      r_s1_v <= 1'b0;
    end else begin
      r_s1_v <= valid_in & ~clear;
      if (valid_in) begin
        r_s1_a <= a;
        r_s1_b <= b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_p <= '0;
      r_s2_v <= 1'b0;
    end else begin
      r_s2_v <= r_s1_v & ~clear;
      if (r_s1_v) begin
        r_s2_p <= w_prod;
      end
    end
  end

  // Clear wins over a completing term: the vector is dropped and f keeps its old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sticky  <= 1'b0;
      f         <= '0;
      valid_out <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      ovf       <= 1'b0;
      if (clear) begin
        r_acc    <= '0;
        r_cnt    <= '0;
        r_sticky <= 1'b0;
      end else if (r_s2_v) begin
        if (w_last) begin
          f         <= w_sum_res;
          valid_out <= 1'b1;
          ovf       <= r_sticky | w_ovf;
          r_acc     <= '0;
          r_cnt     <= '0;
          r_sticky  <= 1'b0;
        end else begin
          r_acc    <= w_sum_res;
          r_cnt    <= r_cnt + 1'b1;
          r_sticky <= r_sticky | w_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_vector.sv
// Bench for mac_vector: three instances (saturating, wrapping, single-term) share stimulus
// and are compared every cycle against a queue-based arithmetic model of the dot product.
module tb_mac_vector;

  localparam int W  = 14;
  localparam int AW = 28;
  localparam int NI = 3;
  localparam longint AMAX = (longint'(1) << (AW - 1)) - 1;
  localparam longint AMIN = -(longint'(1) << (AW - 1));

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic valid_in = 1'b0;
  logic signed [W-1:0] a = '0;
  logic signed [W-1:0] b = '0;

  logic signed [AW-1:0] f0, f1, f2;
  logic vo0, vo1, vo2, ovf0, ovf1, ovf2;

  int n_cmp = 0;
  int n_fail = 0;

  mac_vector #(.WIDTH(W), .ACC_WIDTH(AW), .LEN(4), .SAT(1)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .valid_in(valid_in), .a(a), .b(b),
    .f(f0), .valid_out(vo0), .ovf(ovf0));
  mac_vector #(.WIDTH(W), .ACC_WIDTH(AW), .LEN(4), .SAT(0)) dut_wrap (
    .clk(clk), .reset(reset), .clear(clear), .valid_in(valid_in), .a(a), .b(b),
    .f(f1), .valid_out(vo1), .ovf(ovf1));
  mac_vector #(.WIDTH(W), .ACC_WIDTH(AW), .LEN(1), .SAT(1)) dut_len1 (
    .clk(clk), .reset(reset), .clear(clear), .valid_in(valid_in), .a(a), .b(b),
    .f(f2), .valid_out(vo2), .ovf(ovf2));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reference model: terms become visible two edges after sampling; vectors summed with plain arithmetic.
  typedef struct {
    int     due;
    longint ta;
    longint tb;
  } term_t;

  term_t  pend[$];
  int     edge_n = 0;
  int     m_len[NI] = '{4, 4, 1};
  bit     m_sat[NI] = '{1'b1, 1'b0, 1'b1};
  longint m_acc[NI];
  int     m_cnt[NI];
  bit     m_sticky[NI];
  longint e_f[NI];
  bit     e_vo[NI];
  bit     e_ovf[NI];

  function automatic longint wrap_acc(longint s);
    logic signed [AW-1:0] t;
    t = s[AW-1:0];
    return longint'(t);
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < NI; i++) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_sticky[i] = 1'b0;
      e_f[i] = 0; e_vo[i] = 1'b0; e_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_edge(bit v, longint av, longint bv, bit clr);
    term_t t;
    longint p, s;
    bit o;
    for (int i = 0; i < NI; i++) begin
      e_vo[i] = 1'b0;
      e_ovf[i] = 1'b0;
    end
    if (clr) begin
      pend.delete();
      for (int i = 0; i < NI; i++) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_sticky[i] = 1'b0;
      end
    end else begin
      if (pend.size() > 0 && pend[0].due == edge_n) begin
        t = pend.pop_front();
        p = t.ta * t.tb;
        for (int i = 0; i < NI; i++) begin
          s = m_acc[i] + p;
          o = (s > AMAX) || (s < AMIN);
          if (m_sat[i]) s = (s > AMAX) ? AMAX : ((s < AMIN) ? AMIN : s);
          else          s = wrap_acc(s);
          if (m_cnt[i] == m_len[i] - 1) begin
            e_f[i] = s; e_vo[i] = 1'b1; e_ovf[i] = m_sticky[i] | o;
            m_acc[i] = 0; m_cnt[i] = 0; m_sticky[i] = 1'b0;
          end else begin
            m_acc[i] = s; m_cnt[i]++; m_sticky[i] = m_sticky[i] | o;
          end
        end
      end
      if (v) begin
        t.due = edge_n + 2; t.ta = av; t.tb = bv;
        pend.push_back(t);
      end
    end
    edge_n++;
  endtask

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("vo_sat",   {63'd0, vo0},  {63'd0, e_vo[0]});
    chk("ovf_sat",  {63'd0, ovf0}, {63'd0, e_ovf[0]});
    chk("f_sat",    f0,            e_f[0]);
    chk("vo_wrap",  {63'd0, vo1},  {63'd0, e_vo[1]});
    chk("ovf_wrap", {63'd0, ovf1}, {63'd0, e_ovf[1]});
    chk("f_wrap",   f1,            e_f[1]);
    chk("vo_len1",  {63'd0, vo2},  {63'd0, e_vo[2]});
    chk("ovf_len1", {63'd0, ovf2}, {63'd0, e_ovf[2]});
    chk("f_len1",   f2,            e_f[2]);
  endtask

  task automatic step(bit v, int av, int bv, bit clr);
    valid_in = v;
    a = W'(av);
    b = W'(bv);
    clear = clr;
    @(posedge clk);
    model_edge(v, longint'(av), longint'(bv), clr);
    #1;
    check_outs();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
  endtask

  int av, bv;
  bit rv, rc;

  initial begin
    model_reset();
    #12;
    check_outs();
    @(negedge clk);
    reset = 1'b1;

    // Four consecutive terms -> 100.
    step(1, 1, 2, 0); step(1, 3, 4, 0); step(1, 5, 6, 0); step(1, 7, 8, 0);
    idle(1);
    chk("d_vo_not_early", {63'd0, vo0}, 64'sd0);
    idle(1);
    chk("d_f100", f0, 64'sd100);
    chk("d_vo100", {63'd0, vo0}, 64'sd1);
    idle(2);

    // Same terms with bubbles between them.
    step(1, 1, 2, 0); idle(1); step(1, 3, 4, 0); idle(1);
    step(1, 5, 6, 0); idle(1); step(1, 7, 8, 0); idle(2);
    chk("d_gap_f100", f0, 64'sd100);
    idle(2);

    // Overflow: saturating vs wrapping.
    for (int i = 0; i < 4; i++) step(1, -8192, -8192, 0);
    idle(2);
    chk("d_sat_f", f0, 64'sd134217727);
    chk("d_sat_ovf", {63'd0, ovf0}, 64'sd1);
    chk("d_wrap_f", f1, 64'sd0);
    chk("d_wrap_ovf", {63'd0, ovf1}, 64'sd1);
    idle(2);

    // Eight terms back to back -> two vectors of 24.
    for (int i = 0; i < 8; i++) step(1, 2, 3, 0);
    idle(2);
    chk("d_b2b_f24", f0, 64'sd24);
    idle(2);

    // Partial vector flushed by clear (term presented with clear is also dropped).
    step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 1, 1);
    chk("d_clear_hold_f", f0, 64'sd24);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
    idle(2);
    chk("d_clear_f4", f0, 64'sd4);
    idle(2);

    // Clear on the completing edge suppresses the result.
    for (int i = 0; i < 4; i++) step(1, 5, 5, 0);
    idle(1);
    step(0, 0, 0, 1);
    chk("d_clr_done_vo", {63'd0, vo0}, 64'sd0);
    idle(3);

    // Asynchronous reset mid-vector.
    for (int i = 0; i < 4; i++) step(1, 3, 3, 0);
    idle(2);
    step(1, 1, 1, 0); step(1, 1, 1, 0);
    valid_in = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_outs();
    chk("d_rst_f0", f0, 64'sd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
    idle(2);
    chk("d_rst_f4", f0, 64'sd4);

    // Randomized traffic with occasional clears and extreme operands.
    for (int n = 0; n < 500; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 2) == 0) begin
        av = ($urandom_range(0, 1) != 0) ? -8192 : 8191;
        bv = ($urandom_range(0, 1) != 0) ? -8192 : 8191;
      end else begin
        av = int'($urandom_range(0, 16383)) - 8192;
        bv = int'($urandom_range(0, 16383)) - 8192;
      end
      step(rv, av, bv, rc);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
